// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings
// and the default boot/timeout/counter sizing.
package pipeline_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FAULT    = 2'd3
    } seq_state_e;

    localparam int BOOT_CYCLES_DEF = 2;
    localparam int TIMEOUT_DEF     = 16;
    localparam int CNT_W_DEF       = 32;

endpackage

// File: rtl/pipeline_sequencer_perf_counter.sv
// Free-running event counter: counts cycles with inc high and wraps
// silently on overflow.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count qualified events; reset clears the total
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline control for the 5-stage core: merges load-use stall,
// branch redirect and the data-memory handshake into per-stage enables
// and clears, tracks stage valid bits and keeps stall/flush counters.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int BOOT_CYCLES = BOOT_CYCLES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_d,
    input  logic             pc_jump,
    input  logic             mem_op_m,
    input  logic             dmem_ack,
    output logic             en_f,
    output logic             en_d,
    output logic             en_e,
    output logic             en_m,
    output logic             en_w,
    output logic             clr_d,
    output logic             clr_e,
    output logic             valid_d,
    output logic             valid_e,
    output logic             valid_m,
    output logic             valid_w,
    output logic             dmem_req,
    output logic             mem_fault,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    seq_state_e    state_q;
    seq_state_e    state_n;
    logic [BW-1:0] boot_cnt;
    logic [WW-1:0] wait_cnt;
    logic          mem_busy;
    logic          active;
    logic          run_ctrl;
    logic          wait_clr;
    logic          wait_inc;
    logic          jump_take;
    logic          stall_inc;

    // An access is pending whenever a real load/store sits in M; an ack
    // without such an access is meaningless and never consulted.
    assign mem_busy  = mem_op_m & valid_m;
    assign active    = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    assign dmem_req  = mem_busy & active & ~rst;
    assign mem_fault = (state_q == ST_FAULT) & ~rst;
    assign state     = state_q;
    assign stall_inc = active & ~en_f & ~rst;

    // Next state and Mealy enables/clears; memory freeze beats jump,
    // jump beats load-use stall
    always_comb begin
        state_n   = state_q;
        en_f      = 1'b0;
        en_d      = 1'b0;
        en_e      = 1'b0;
        en_m      = 1'b0;
        en_w      = 1'b0;
        clr_d     = 1'b0;
        clr_e     = 1'b0;
        run_ctrl  = 1'b0;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        jump_take = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mem_busy && !dmem_ack) begin
                    en_w     = 1'b1;
                    wait_clr = 1'b1;
                    state_n  = ST_MEM_WAIT;
                end else begin
                    run_ctrl = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy && dmem_ack) begin
                    run_ctrl = 1'b1;
                    state_n  = ST_RUN;
                end else begin
                    en_w     = 1'b1;
                    wait_inc = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_n = ST_FAULT;
                    end
                end
            end
            default: begin
                state_n = ST_FAULT;
            end
        endcase
        if (run_ctrl) begin
            if (pc_jump) begin
                {en_f, en_d, en_e, en_m, en_w} = 5'b11111;
                clr_d     = 1'b1;
                clr_e     = 1'b1;
                jump_take = 1'b1;
            end else if (stall_d) begin
                {en_e, en_m, en_w} = 3'b111;
                clr_e = 1'b1;
            end else begin
                {en_f, en_d, en_e, en_m, en_w} = 5'b11111;
            end
        end
        if (rst) begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
            clr_d     = 1'b0;
            clr_e     = 1'b0;
            jump_take = 1'b0;
        end
    end

    // State register plus the boot and memory-wait cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            boot_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == ST_BOOT && boot_cnt != BOOT_LAST) begin
                boot_cnt <= boot_cnt + BW'(1);
            end
            if (wait_clr) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

    // Valid bits advance with their stage enable; W gets a bubble when M holds
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d <= 1'b0;
            valid_e <= 1'b0;
            valid_m <= 1'b0;
            valid_w <= 1'b0;
        end else begin
            if (en_d) begin
                valid_d <= ~clr_d;
            end
            if (en_e) begin
                valid_e <= clr_e ? 1'b0 : valid_d;
            end
            if (en_m) begin
                valid_m <= valid_e;
            end
            if (en_w) begin
                valid_w <= en_m ? valid_m : 1'b0;
            end
        end
    end

    perf_counter #(.CNT_W(CNT_W)) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (jump_take),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed testbench for pipeline_sequencer: boot, load-use, jump/stall
// priority, memory wait, timeout fault and reset during a wait.
module tb_pipeline_sequencer;

    logic        clk;
    logic        rst;
    logic        stall_d;
    logic        pc_jump;
    logic        mem_op_m;
    logic        dmem_ack;
    logic        en_f, en_d, en_e, en_m, en_w;
    logic        clr_d, clr_e;
    logic        valid_d, valid_e, valid_m, valid_w;
    logic        dmem_req;
    logic        mem_fault;
    logic [1:0]  state;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [4:0]  en_vec;

    int checks;
    int failures;

    assign en_vec = {en_f, en_d, en_e, en_m, en_w};

    pipeline_sequencer #(
        .BOOT_CYCLES (2),
        .TIMEOUT     (16),
        .CNT_W       (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_d   (stall_d),
        .pc_jump   (pc_jump),
        .mem_op_m  (mem_op_m),
        .dmem_ack  (dmem_ack),
        .en_f      (en_f),
        .en_d      (en_d),
        .en_e      (en_e),
        .en_m      (en_m),
        .en_w      (en_w),
        .clr_d     (clr_d),
        .clr_e     (clr_e),
        .valid_d   (valid_d),
        .valid_e   (valid_e),
        .valid_m   (valid_m),
        .valid_w   (valid_w),
        .dmem_req  (dmem_req),
        .mem_fault (mem_fault),
        .state     (state),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_d = 1'b0; pc_jump = 1'b0; mem_op_m = 1'b0; dmem_ack = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++;
        if (en_vec !== 5'b00000) begin failures++; $display("FAIL reset_en got=%b exp=00000", en_vec); end
        checks++;
        if ({valid_d, valid_e, valid_m, valid_w} !== 4'b0000) begin
            failures++; $display("FAIL reset_valid got=%b exp=0000", {valid_d, valid_e, valid_m, valid_w});
        end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_boot();
        #1;
        checks++;
        if (state !== 2'd0 || en_vec !== 5'b00000) begin
            failures++; $display("FAIL boot_c1 got state=%0d en=%b exp state=0 en=00000", state, en_vec);
        end
        tick();
        checks++;
        if (state !== 2'd0 || en_vec !== 5'b00000) begin
            failures++; $display("FAIL boot_c2 got state=%0d en=%b exp state=0 en=00000", state, en_vec);
        end
        tick();
        checks++;
        if (state !== 2'd1 || en_f !== 1'b1) begin
            failures++; $display("FAIL boot_run got state=%0d en_f=%b exp state=1 en_f=1", state, en_f);
        end
        tick();
        checks++;
        if (valid_d !== 1'b1 || valid_e !== 1'b0) begin
            failures++; $display("FAIL boot_valid_d got d=%b e=%b exp d=1 e=0", valid_d, valid_e);
        end
        tick();
        tick();
        checks++;
        if (valid_m !== 1'b1 || valid_w !== 1'b0) begin
            failures++; $display("FAIL boot_valid_m got m=%b w=%b exp m=1 w=0", valid_m, valid_w);
        end
        tick();
        checks++;
        if (valid_w !== 1'b1 || stall_cnt !== 32'd0) begin
            failures++; $display("FAIL boot_valid_w got w=%b stall=%0d exp w=1 stall=0", valid_w, stall_cnt);
        end
    endtask

    task automatic test_load_use();
        stall_d = 1'b1;
        #1;
        checks++;
        if (en_vec !== 5'b00111 || clr_e !== 1'b1 || clr_d !== 1'b0) begin
            failures++; $display("FAIL load_use_ctrl got en=%b clr_d=%b clr_e=%b exp en=00111 clr_d=0 clr_e=1",
                                 en_vec, clr_d, clr_e);
        end
        tick();
        stall_d = 1'b0;
        checks++;
        if (valid_e !== 1'b0 || valid_d !== 1'b1) begin
            failures++; $display("FAIL load_use_valid got d=%b e=%b exp d=1 e=0", valid_d, valid_e);
        end
        checks++;
        if (stall_cnt !== 32'd1) begin failures++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_jump_stall();
        pc_jump = 1'b1;
        stall_d = 1'b1;
        #1;
        checks++;
        if (en_vec !== 5'b11111 || clr_d !== 1'b1 || clr_e !== 1'b1) begin
            failures++; $display("FAIL jump_ctrl got en=%b clr_d=%b clr_e=%b exp en=11111 clr_d=1 clr_e=1",
                                 en_vec, clr_d, clr_e);
        end
        tick();
        pc_jump = 1'b0;
        stall_d = 1'b0;
        checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd1) begin
            failures++; $display("FAIL jump_cnt got flush=%0d stall=%0d exp flush=1 stall=1", flush_cnt, stall_cnt);
        end
        checks++;
        if (valid_d !== 1'b0 || valid_e !== 1'b0) begin
            failures++; $display("FAIL jump_valid got d=%b e=%b exp d=0 e=0", valid_d, valid_e);
        end
        tick();
        tick();
        tick();
        checks++;
        if (valid_m !== 1'b1) begin failures++; $display("FAIL jump_refill got valid_m=%b exp=1", valid_m); end
    endtask

    task automatic test_mem_wait();
        mem_op_m = 1'b1;
        dmem_ack = 1'b0;
        #1;
        checks++;
        if (state !== 2'd1 || en_vec !== 5'b00001 || dmem_req !== 1'b1) begin
            failures++; $display("FAIL mem_freeze got state=%0d en=%b req=%b exp state=1 en=00001 req=1",
                                 state, en_vec, dmem_req);
        end
        tick();
        checks++;
        if (state !== 2'd2 || en_m !== 1'b0 || dmem_req !== 1'b1 || valid_w !== 1'b0) begin
            failures++; $display("FAIL mem_wait1 got state=%0d en_m=%b req=%b vw=%b exp state=2 en_m=0 req=1 vw=0",
                                 state, en_m, dmem_req, valid_w);
        end
        tick();
        checks++;
        if (state !== 2'd2 || en_m !== 1'b0) begin
            failures++; $display("FAIL mem_wait2 got state=%0d en_m=%b exp state=2 en_m=0", state, en_m);
        end
        tick();
        dmem_ack = 1'b1;
        #1;
        checks++;
        if (state !== 2'd2 || en_vec !== 5'b11111) begin
            failures++; $display("FAIL mem_ack got state=%0d en=%b exp state=2 en=11111", state, en_vec);
        end
        tick();
        mem_op_m = 1'b0;
        dmem_ack = 1'b0;
        checks++;
        if (state !== 2'd1 || stall_cnt !== 32'd4) begin
            failures++; $display("FAIL mem_done got state=%0d stall=%0d exp state=1 stall=4", state, stall_cnt);
        end
    endtask

    task automatic test_timeout();
        mem_op_m = 1'b1;
        dmem_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        checks++;
        if (state !== 2'd2 || mem_fault !== 1'b0) begin
            failures++; $display("FAIL timeout_early got state=%0d fault=%b exp state=2 fault=0", state, mem_fault);
        end
        tick();
        checks++;
        if (state !== 2'd3 || mem_fault !== 1'b1 || en_vec !== 5'b00000 || dmem_req !== 1'b0) begin
            failures++; $display("FAIL timeout_fault got state=%0d fault=%b en=%b req=%b exp state=3 fault=1 en=00000 req=0",
                                 state, mem_fault, en_vec, dmem_req);
        end
        checks++;
        if (stall_cnt !== 32'd21) begin failures++; $display("FAIL timeout_cnt got=%0d exp=21", stall_cnt); end
        dmem_ack = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 2'd3 || en_vec !== 5'b00000 || stall_cnt !== 32'd21) begin
            failures++; $display("FAIL fault_hold got state=%0d en=%b stall=%0d exp state=3 en=00000 stall=21",
                                 state, en_vec, stall_cnt);
        end
        rst = 1'b1;
        dmem_ack = 1'b0;
        mem_op_m = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || mem_fault !== 1'b0 || stall_cnt !== 32'd0) begin
            failures++; $display("FAIL fault_reset got state=%0d fault=%b stall=%0d exp state=0 fault=0 stall=0",
                                 state, mem_fault, stall_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        tick();
        tick();
        checks++;
        if (state !== 2'd1) begin failures++; $display("FAIL reboot got state=%0d exp=1", state); end
        tick();
        tick();
        tick();
        mem_op_m = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 2'd2 || stall_cnt !== 32'd2) begin
            failures++; $display("FAIL midwait_setup got state=%0d stall=%0d exp state=2 stall=2", state, stall_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || en_vec !== 5'b00000) begin
            failures++; $display("FAIL midwait_force got req=%b en=%b exp req=0 en=00000", dmem_req, en_vec);
        end
        tick();
        checks++;
        if (state !== 2'd0 || dmem_req !== 1'b0 || {valid_d, valid_e, valid_m, valid_w} !== 4'b0000) begin
            failures++; $display("FAIL midwait_reset got state=%0d req=%b valid=%b exp state=0 req=0 valid=0000",
                                 state, dmem_req, {valid_d, valid_e, valid_m, valid_w});
        end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            failures++; $display("FAIL midwait_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        rst = 1'b0;
        mem_op_m = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_boot();
        test_load_use();
        test_jump_stall();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central pipeline-control block for the 5-stage RV32I core (F/D/E/M/W).
- Merges three inputs into per-stage register enables and clears: the hazard unit's raw load-use stall, the branch/jump redirect, and a multi-cycle data-memory handshake.
- Tracks per-stage valid bits, detects data-memory timeouts, and keeps stall/flush performance counters.
- Sits between the hazard unit and all pipeline registers.

Parameters:
- BOOT_CYCLES, 2, cycles after reset with every stage enable held low (imem warm-up).
- TIMEOUT, 16, MEM_WAIT cycles without dmem_ack before entering FAULT.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stall_d  in  1  load-use stall request from the hazard unit
- pc_jump  in  1  taken branch/jump resolved in E
- mem_op_m  in  1  instruction in M is a load or store
- dmem_ack  in  1  data memory completes the M-stage access this cycle
- en_f, en_d, en_e, en_m, en_w  out  1 each  pipeline register enables
- clr_d, clr_e  out  1 each  synchronous bubble insert into the D and E registers
- valid_d, valid_e, valid_m, valid_w  out  1 each  stage holds a real instruction
- dmem_req  out  1  data-memory request (mem_op_m & valid_m & state in RUN/MEM_WAIT)
- mem_fault  out  1  high in FAULT
- state  out  2  BOOT=0, RUN=1, MEM_WAIT=2, FAULT=3
- stall_cnt  out  CNT_W  cycles with en_f low while in RUN/MEM_WAIT
- flush_cnt  out  CNT_W  accepted pc_jump events

Behaviour:
Clock, reset and timing:
- Single clock, clk. Reset is rst, synchronous and active-high, and overrides everything.
- At the rst edge: state=BOOT, boot_cnt=0, wait_cnt=0, valid_*=0, stall_cnt=flush_cnt=0.
- While rst is high, all en_*, clr_*, dmem_req and mem_fault are forced to 0.
- Enables and clears are combinational (Mealy) from state and inputs. Valid bits and counters are registered.
- Reset asserted mid-MEM_WAIT or in FAULT returns to BOOT at the next edge; the outstanding request is abandoned.

BOOT:
- All enables and clears are 0.
- boot_cnt increments each cycle. When boot_cnt==BOOT_CYCLES-1, go to RUN.

RUN, evaluated in priority order (freeze > jump > load-use):
1. freeze = mem_op_m & valid_m & !dmem_ack.
   - en_f/d/e/m = 0; en_w = 1, and W takes a bubble (valid_w <= 0).
   - Go to MEM_WAIT with wait_cnt <= 0.
   - pc_jump and stall_d are ignored; they persist because the upstream stages are frozen.
2. Else pc_jump: all en=1, clr_d=1, clr_e=1, flush_cnt++. This applies even if stall_d is also high.
3. Else stall_d: en_f=en_d=0, en_e/m/w=1, clr_e=1.
4. Else: all en=1, no clears.

MEM_WAIT:
- Outputs are as for freeze; dmem_req is held high.
- On dmem_ack: outputs as RUN with freeze=0, applying the same priority to pc_jump/stall_d in that cycle; go to RUN.
- On !dmem_ack: wait_cnt++. If wait_cnt==TIMEOUT-1, go to FAULT.
- Total unacked cycles before FAULT = 1 (RUN) + TIMEOUT.

FAULT:
- All enables 0, mem_fault=1, dmem_req=0.
- Only rst exits FAULT.

Valid tracking:
- Each valid updates only when its stage enable is high.
- valid_d <= !clr_d.
- valid_e <= clr_e ? 0 : valid_d.
- valid_m <= valid_e.
- valid_w <= valid_m, or 0 when en_m=0 and en_w=1.
- dmem_ack while dmem_req=0 is ignored.

Counters:
- Counters wrap on overflow.
- stall_cnt counts load-use cycles and MEM_WAIT/freeze cycles; it does not count BOOT or FAULT cycles.

Decomposition:
- Shared package holds the state encodings (ST_BOOT, ST_RUN, ST_MEM_WAIT, ST_FAULT) and the BOOT_CYCLES/TIMEOUT defaults.
- One natural sub-module: perf_counter (enable + wrap, CNT_W wide), instantiated twice.
- The FSM, enable logic and valid pipeline stay in the top module.

Test Plan:
- Boot: rst high 1 cycle, then low → state=0 and all en=0 for 2 cycles; cycle 3 state=1, en_f=1; valid_d=1 one cycle later.
- Load-use: in RUN, stall_d=1 for 1 cycle → en_f=en_d=0, clr_e=1, valid_e=0 next cycle, stall_cnt=1.
- Jump + stall together: pc_jump=1, stall_d=1 → all en=1, clr_d=clr_e=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_op_m=1, valid_m=1, dmem_ack low 3 cycles then high → en_m=0 for 3 cycles, state=2 after the first, ack cycle en_m=1, then state=1; stall_cnt=4.
- Timeout: dmem_ack never asserted → state=3 and mem_fault=1 after 17 unacked cycles; all en=0 until rst; rst → state=0.
- Reset mid-wait: rst during MEM_WAIT → next cycle state=0, dmem_req=0, valids 0, counters 0.
